// File: rtl/wbq_pkg.sv
// wbq_pkg: shared constants and the queue entry layout for wb_write_queue.
// Contents: default DEPTH/AW/DW, the register-zero address, wbq_entry_t.
// The entry struct is sized by the package defaults; the top's AW/DW track them.
package wbq_pkg;

  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_AW    = 5;
  localparam int WBQ_DW    = 32;

  // Writes to register zero are discarded by the register file, so a queued
  // entry targeting it is carried as an invalid bubble.
  localparam logic [WBQ_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [WBQ_AW-1:0] wr;
    logic [WBQ_DW-1:0] d;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// wbq_match: forwarding lookup over the write queue for one read address.
// Ports: i_valid/i_wr per-slot entry fields, i_head oldest slot, i_addr read
//        address; o_hit = some valid entry targets i_addr (never for r0),
//        o_idx = slot of the youngest matching entry (meaningful when o_hit).
module wbq_match #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 5,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_valid,
  input  logic [AW-1:0]    i_wr [DEPTH],
  input  logic [PW-1:0]    i_head,
  input  logic [AW-1:0]    i_addr,
  output logic             o_hit,
  output logic [PW-1:0]    o_idx
);

  // Walk slots oldest to youngest starting at the head; the last match wins,
  // which is the entry closest to the tail. Unoccupied slots always have
  // valid=0, so scanning all DEPTH slots needs no occupancy check.
  always_comb begin
    o_hit = 1'b0;
    o_idx = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_valid[i_head + PW'(k)] && (i_addr != '0) &&
          (i_wr[i_head + PW'(k)] == i_addr)) begin
        o_hit = 1'b1;
        o_idx = i_head + PW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: merges pipeline writeback (PWe/PWr/PD) with queued multi-cycle
// results (SValid/SReady/SWr/SD) onto the register file port (We/Wr/D); exposes
// pending entries to decode (Ra/Rb -> HitA/HitB, FwdA/FwdB), plus Count/Empty.
// Optional macro WBQ_FWD_EN: builds the FwdA/FwdB data mux; otherwise tied to 0.
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter  int DEPTH = WBQ_DEPTH,
  parameter  int AW    = WBQ_AW,
  parameter  int DW    = WBQ_DW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          PWe,
  input  logic [AW-1:0] PWr,
  input  logic [DW-1:0] PD,
  input  logic          SValid,
  output logic          SReady,
  input  logic [AW-1:0] SWr,
  input  logic [DW-1:0] SD,
  output logic          We,
  output logic [AW-1:0] Wr,
  output logic [DW-1:0] D,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic          HitA,
  output logic          HitB,
  output logic [DW-1:0] FwdA,
  output logic [DW-1:0] FwdB,
  output logic [CW-1:0] Count,
  output logic          Empty
);

  wbq_entry_t    r_q [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  wbq_entry_t       w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_squash;
  logic [DEPTH-1:0] w_valid;
  logic [AW-1:0]    w_wr [DEPTH];
  logic             w_hit_a;
  logic             w_hit_b;
  logic [PW-1:0]    w_idx_a;
  logic [PW-1:0]    w_idx_b;

  assign w_head = r_q[r_head];
  assign SReady = (r_count != CW'(DEPTH));
  assign Count  = r_count;
  assign Empty  = (r_count == '0);
  assign w_push = SValid && SReady;
  // Valid bits are only ever set in occupied slots. A valid head yields to the
  // pipeline; a squashed or r0 head is dropped every cycle.
  assign w_pop    = (r_count != '0) && (!w_head.valid || !PWe);
  assign w_squash = PWe && (PWr != REG_ZERO);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      // A pipeline write supersedes every older queued write to that register.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_squash && r_q[i].valid && (r_q[i].wr == PWr)) r_q[i].valid <= 1'b0;
      end
      if (w_pop) begin
        r_q[r_head].valid <= 1'b0;
        r_head            <= r_head + PW'(1);
      end
      // Last assignment wins, so a same-edge push is never squashed.
      if (w_push) begin
        r_q[r_tail].valid <= (SWr != REG_ZERO);
        r_q[r_tail].wr    <= SWr;
        r_q[r_tail].d     <= SD;
        r_tail            <= r_tail + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Register file port mux; nothing is written while Clr is held.
  always_comb begin
    We = 1'b0;
    Wr = '0;
    D  = '0;
    if (!Clr) begin
      if (PWe) begin
        We = 1'b1;
        Wr = PWr;
        D  = PD;
      end else if (w_head.valid) begin
        We = 1'b1;
        Wr = w_head.wr;
        D  = w_head.d;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_q[i].valid;
      w_wr[i]    = r_q[i].wr;
    end
  end

  wbq_match #(.DEPTH(DEPTH), .AW(AW)) u_match_a (
    .i_valid(w_valid), .i_wr(w_wr), .i_head(r_head), .i_addr(Ra),
    .o_hit(w_hit_a), .o_idx(w_idx_a)
  );

  wbq_match #(.DEPTH(DEPTH), .AW(AW)) u_match_b (
    .i_valid(w_valid), .i_wr(w_wr), .i_head(r_head), .i_addr(Rb),
    .o_hit(w_hit_b), .o_idx(w_idx_b)
  );

  assign HitA = w_hit_a;
  assign HitB = w_hit_b;

`ifdef WBQ_FWD_EN
  assign FwdA = w_hit_a ? r_q[w_idx_a].d : '0;
  assign FwdB = w_hit_b ? r_q[w_idx_b].d : '0;
`else
  // Decode stalls on a hit instead of forwarding; match indices go unused.
  logic w_unused_idx;
  assign w_unused_idx = ^{w_idx_a, w_idx_b};
  assign FwdA = '0;
  assign FwdB = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed, table-driven check of wb_write_queue.
// Each table row is one clock cycle: inputs driven after the rising edge,
// outputs compared at the falling edge; then an async-clear sequence.
module tb_wb_write_queue;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        PWe = 1'b0;
  logic [4:0]  PWr = '0;
  logic [31:0] PD = '0;
  logic        SValid = 1'b0;
  logic        SReady;
  logic [4:0]  SWr = '0;
  logic [31:0] SD = '0;
  logic        We;
  logic [4:0]  Wr;
  logic [31:0] D;
  logic [4:0]  Ra = '0;
  logic [4:0]  Rb = '0;
  logic        HitA, HitB;
  logic [31:0] FwdA, FwdB;
  logic [2:0]  Count;
  logic        Empty;

  int errors = 0;
  int checks = 0;

  wb_write_queue dut (
    .Clk(Clk), .Clr(Clr), .PWe(PWe), .PWr(PWr), .PD(PD),
    .SValid(SValid), .SReady(SReady), .SWr(SWr), .SD(SD),
    .We(We), .Wr(Wr), .D(D), .Ra(Ra), .Rb(Rb),
    .HitA(HitA), .HitB(HitB), .FwdA(FwdA), .FwdB(FwdB),
    .Count(Count), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        pwe;  logic [4:0] pwr; logic [31:0] pd;
    logic        sv;   logic [4:0] swr; logic [31:0] sd;
    logic [4:0]  ra;   logic [4:0] rb;
    logic        we;   logic [4:0] wr;  logic [31:0] d;
    logic        srdy; logic [2:0] cnt;
    logic        hita; logic [31:0] fwda; logic hitb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pwe, input logic [4:0] pwr, input logic [31:0] pd,
                     input logic sv, input logic [4:0] swr, input logic [31:0] sd,
                     input logic [4:0] ra, input logic [4:0] rb,
                     input logic we, input logic [4:0] wr, input logic [31:0] d,
                     input logic srdy, input logic [2:0] cnt,
                     input logic hita, input logic [31:0] fwda, input logic hitb);
    vec_t v;
    v.pwe = pwe; v.pwr = pwr; v.pd = pd; v.sv = sv; v.swr = swr; v.sd = sd;
    v.ra = ra; v.rb = rb; v.we = we; v.wr = wr; v.d = d; v.srdy = srdy;
    v.cnt = cnt; v.hita = hita; v.fwda = fwda; v.hitb = hitb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd_exp(input logic [31:0] v);
`ifdef WBQ_FWD_EN
    return v;
`else
    return (v == 32'h0) ? 32'h0 : 32'h0;
`endif
  endfunction

  initial begin
    //   pwe pwr pd          sv swr sd            ra  rb   we wr d             srdy cnt hita fwda          hitb
    // reset state, then single push drained next cycle
    add(0, 0,  0,          0, 0,  0,            0,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    add(0, 0,  0,          1, 5,  32'hA5A5A5A5, 5,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            5,  0,   1, 5,  32'hA5A5A5A5, 1, 1, 1, 32'hA5A5A5A5, 0);
    add(0, 0,  0,          0, 0,  0,            5,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    // fill while the pipeline owns the port
    add(1, 1,  32'h100,    1, 10, 32'hA0,       0,  0,   1, 1,  32'h100,      1, 0, 0, 0,            0);
    add(1, 2,  32'h200,    1, 11, 32'hB0,       0,  0,   1, 2,  32'h200,      1, 1, 0, 0,            0);
    add(1, 3,  32'h300,    1, 12, 32'hC0,       0,  0,   1, 3,  32'h300,      1, 2, 0, 0,            0);
    add(1, 4,  32'h400,    1, 13, 32'hD0,       0,  0,   1, 4,  32'h400,      1, 3, 0, 0,            0);
    add(1, 6,  32'h600,    1, 14, 32'hE0,       13, 10,  1, 6,  32'h600,      0, 4, 1, 32'hD0,       1);
    // drain in push order
    add(0, 0,  0,          0, 0,  0,            0,  0,   1, 10, 32'hA0,       0, 4, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            0,  14,  1, 11, 32'hB0,       1, 3, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            0,  0,   1, 12, 32'hC0,       1, 2, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            0,  0,   1, 13, 32'hD0,       1, 1, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            0,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    // squash: r7=0x11 queued, pipeline writes r7=0x22
    add(0, 0,  0,          1, 7,  32'h11,       7,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    add(1, 7,  32'h22,     0, 0,  0,            7,  0,   1, 7,  32'h22,       1, 1, 1, 32'h11,       0);
    add(0, 0,  0,          0, 0,  0,            7,  0,   0, 0,  0,            1, 1, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            7,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    // youngest-match forwarding, r3=1 then r3=2
    add(1, 9,  32'h99,     1, 3,  32'h1,        3,  0,   1, 9,  32'h99,       1, 0, 0, 0,            0);
    add(1, 9,  32'h99,     1, 3,  32'h2,        3,  0,   1, 9,  32'h99,       1, 1, 1, 32'h1,        0);
    add(1, 9,  32'h99,     0, 0,  0,            3,  0,   1, 9,  32'h99,       1, 2, 1, 32'h2,        0);
    add(1, 9,  32'h99,     0, 0,  0,            0,  3,   1, 9,  32'h99,       1, 2, 0, 0,            1);
    add(0, 0,  0,          0, 0,  0,            3,  0,   1, 3,  32'h1,        1, 2, 1, 32'h2,        0);
    add(0, 0,  0,          0, 0,  0,            3,  0,   1, 3,  32'h2,        1, 1, 1, 32'h2,        0);
    add(0, 0,  0,          0, 0,  0,            3,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    // r0 bubble pops even under PWe
    add(1, 8,  32'h88,     1, 0,  32'hFF,       0,  0,   1, 8,  32'h88,       1, 0, 0, 0,            0);
    add(1, 8,  32'h88,     0, 0,  0,            0,  0,   1, 8,  32'h88,       1, 1, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            0,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    // simultaneous push and pop
    add(0, 0,  0,          1, 20, 32'h20,       0,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    add(0, 0,  0,          1, 21, 32'h21,       0,  0,   1, 20, 32'h20,       1, 1, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            0,  0,   1, 21, 32'h21,       1, 1, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            0,  0,   0, 0,  0,            1, 0, 0, 0,            0);
    // entry pushed on the squashing edge survives
    add(1, 15, 32'h15,     1, 15, 32'h55,       0,  0,   1, 15, 32'h15,       1, 0, 0, 0,            0);
    add(0, 0,  0,          0, 0,  0,            15, 0,   1, 15, 32'h55,       1, 1, 1, 32'h55,       0);
    add(0, 0,  0,          0, 0,  0,            0,  0,   0, 0,  0,            1, 0, 0, 0,            0);

    repeat (2) @(posedge Clk);
    #2 Clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clk);
      #1;
      PWe = vecs[i].pwe; PWr = vecs[i].pwr; PD = vecs[i].pd;
      SValid = vecs[i].sv; SWr = vecs[i].swr; SD = vecs[i].sd;
      Ra = vecs[i].ra; Rb = vecs[i].rb;
      @(negedge Clk);
      chk($sformatf("v%0d.We", i),     32'(We),     32'(vecs[i].we));
      chk($sformatf("v%0d.Wr", i),     32'(Wr),     32'(vecs[i].wr));
      chk($sformatf("v%0d.D", i),      D,           vecs[i].d);
      chk($sformatf("v%0d.SReady", i), 32'(SReady), 32'(vecs[i].srdy));
      chk($sformatf("v%0d.Count", i),  32'(Count),  32'(vecs[i].cnt));
      chk($sformatf("v%0d.Empty", i),  32'(Empty),  32'(vecs[i].cnt == 3'd0));
      chk($sformatf("v%0d.HitA", i),   32'(HitA),   32'(vecs[i].hita));
      chk($sformatf("v%0d.FwdA", i),   FwdA,        fwd_exp(vecs[i].fwda));
      chk($sformatf("v%0d.HitB", i),   32'(HitB),   32'(vecs[i].hitb));
    end

    // Async clear with three entries parked behind the pipeline.
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk);
      #1;
      PWe = 1'b1; PWr = 5'd30; PD = 32'h30;
      SValid = 1'b1; SWr = 5'(k); SD = 32'(k);
      Ra = 5'd2; Rb = 5'd0;
    end
    @(posedge Clk);
    #1 SValid = 1'b0;
    @(negedge Clk);
    chk("pre_clr.Count", 32'(Count), 32'd3);
    chk("pre_clr.HitA",  32'(HitA),  32'd1);
    chk("pre_clr.We",    32'(We),    32'd1);
    #2 Clr = 1'b1;
    #1;
    chk("clr.Count",  32'(Count),  32'd0);
    chk("clr.We",     32'(We),     32'd0);
    chk("clr.SReady", 32'(SReady), 32'd1);
    chk("clr.Empty",  32'(Empty),  32'd1);
    chk("clr.HitA",   32'(HitA),   32'd0);
    @(negedge Clk);
    Clr = 1'b0;
    PWe = 1'b0;
    #1;
    chk("post_clr.We",    32'(We),    32'd0);
    chk("post_clr.Count", 32'(Count), 32'd0);
    PWe = 1'b1;
    #1;
    chk("post_clr.PWe_We", 32'(We), 32'd1);
    chk("post_clr.PWe_Wr", 32'(Wr), 32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-side front end for the 32x32 register file: merges the single-cycle pipeline writeback with results from a multi-cycle producer (mult/div, load miss) into the register file's one write port (Wr, D, We). The multi-cycle results are buffered in a small in-order queue and drained whenever the pipeline leaves the port idle. Pending entries are exposed to the read side so decode can forward or stall.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16
- AW, 5: register address width
- DW, 32: data width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Clr  in  1  asynchronous, active-high reset
- PWe  in  1  primary (pipeline) write enable; owns the port this cycle
- PWr  in  AW  primary destination register
- PD  in  DW  primary write data
- SValid  in  1  secondary result valid
- SReady  out  1  queue can accept; SValid and SReady both high at an edge is a push
- SWr  in  AW  secondary destination register
- SD  in  DW  secondary data
- We  out  1  register file write enable
- Wr  out  AW  register file write address
- D  out  DW  register file write data
- Ra, Rb  in  AW  decode read addresses
- HitA, HitB  out  1  a valid queued entry targets Ra / Rb
- FwdA, FwdB  out  DW  data of youngest matching entry
- Count  out  $clog2(DEPTH)+1  occupied entries, including squashed ones
- Empty  out  1  Count == 0

## Operation
- Queue entry fields: valid, wr, d. The queue uses circular head/tail pointers of $clog2(DEPTH) bits that wrap naturally. Count is held as a separate register.
- Push: on SValid & SReady, the entry is written at the tail with valid = (SWr != 0). SWr == 0 still consumes a slot and pops as a bubble.
- SReady = (Count != DEPTH). It does not depend on a same-cycle pop, so there is no pass-through when full.
- Write port mux (combinational):
  - If PWe: We=1, Wr=PWr, D=PD.
  - Else if the head is valid: We=1, Wr=head.wr, D=head.d.
  - Otherwise: We=0, Wr=0, D=0.
- Pop:
  - A valid head pops only when PWe=0.
  - An invalid (squashed or $0) head pops every cycle regardless of PWe, with no write.
- Squash: primary writes are younger than everything already queued. On an edge with PWe=1 and PWr != 0, every entry already in the queue with valid=1 and wr==PWr gets valid cleared. An entry pushed on that same edge is not squashed.
- Push and pop on the same edge: Count is unchanged and both pointers advance.
- Forwarding lookup:
  - HitA=1 when Ra != 0 and some valid entry has wr==Ra.
  - FwdA = d of the youngest such entry, i.e. the one closest to the tail. FwdA=0 when there is no hit.
  - B side is identical. The primary input is not considered.

## Timing
- Reset values: pointers 0, Count 0, all valid bits 0. Outputs: We=0, Wr=0, D=0, SReady=1, Empty=1, HitA/HitB=0, FwdA/FwdB=0.
- Primary path has zero latency: PWe to We is combinational.
- An entry pushed at edge k can reach We in cycle k+1 at the earliest. It is written at edge k+1 if PWe=0 in that cycle.
- Sustained throughput is one push and one pop per cycle.
- Hit/Fwd reflect queue state after the last edge; they are combinational from Ra/Rb.
- Clr asserted mid-drain discards all entries immediately. No write is issued while Clr is high.

## Configuration
- WBQ_FWD_EN defined: FwdA/FwdB are driven as above.
- WBQ_FWD_EN undefined:
  - FwdA/FwdB are tied to 0 and the youngest-match data mux is not built.
  - HitA/HitB are still produced, so decode stalls instead of forwarding.

## Structure
- Package wbq_pkg holds:
  - default DEPTH/AW/DW constants
  - typedef wbq_entry_t {valid, wr[AW], d[DW]}
  - the register-zero constant
- Sub-module wbq_match: takes the entry array, head pointer and a read address, and returns hit plus youngest-match index. It is instantiated once per read port.

## Test plan
- Reset, then push SWr=5/SD=0xA5A5A5A5 with PWe=0 → next cycle We=1, Wr=5, D=0xA5A5A5A5; Empty=1 the cycle after.
- Fill 4 entries while PWe=1 continuously → SReady=0, Count=4, no queue write. Drop PWe → four drains on consecutive cycles in push order.
- Queue holds entry r7=0x11; PWe with PWr=7, PD=0x22 → after the edge HitA(Ra=7)=0. The squashed head pops with We=0 and r7 is never rewritten with 0x11.
- Queue holds r3=0x1 then r3=0x2 → with Ra=3: HitA=1, FwdA=0x2. With Ra=0: HitA=0. Without WBQ_FWD_EN: FwdA=0 and HitA=1.
- Push SWr=0 → Count increments, and the entry pops without We even while PWe=1.
- Assert Clr asynchronously with 3 entries queued → Count=0, We=0, SReady=1 immediately.
